// File: rtl/pool_window_pe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pool_window_pe_pkg
//  Description : Shared constants and types for the pooling window PE.
//  Revision    : 1.0 - initial release
// ============================================================================
package pool_window_pe_pkg;

    // Default sample width shared with the feature-buffer path.
    localparam int FEATURE_WIDTH_DEF = 16;

    // Runtime pooling mode encodings (cfg_mode).
    localparam logic POOL_MODE_MAX = 1'b0;
    localparam logic POOL_MODE_AVG = 1'b1;

    // Window controller state.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } pool_state_t;

endpackage : pool_window_pe_pkg
`default_nettype wire

// File: rtl/pool_window_pe_if.sv
`default_nettype none
// ============================================================================
//  Module      : pool_window_pe_if
//  Description : Valid/ready sample-in and result-out streams of the PE.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pool_window_pe_if
    import pool_window_pe_pkg::*;
#(
    parameter int LANES         = 4,
    parameter int FEATURE_WIDTH = FEATURE_WIDTH_DEF
);
    logic                             in_valid;
    logic                             in_ready;
    logic [LANES*FEATURE_WIDTH-1:0]   in_data;
    logic                             out_valid;
    logic                             out_ready;
    logic [LANES*FEATURE_WIDTH-1:0]   out_data;

    // Producer of samples / consumer of results.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The pooling PE itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface : pool_window_pe_if
`default_nettype wire

// File: rtl/pool_window_pe_lane_alu.sv
`default_nettype none
// ============================================================================
//  Module      : pool_lane_alu
//  Description : One lane's combine (max / add) and finalise (shift, saturate).
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_lane_alu
    import pool_window_pe_pkg::*;
#(
    parameter int FEATURE_WIDTH = FEATURE_WIDTH_DEF,
    parameter int ACC_W         = FEATURE_WIDTH + 4
)(
    input  logic                            mode,
    input  logic                            first,
    input  logic [3:0]                      shift,
    input  logic signed [ACC_W-1:0]         acc,
    input  logic signed [FEATURE_WIDTH-1:0] sample,
    output logic signed [ACC_W-1:0]         acc_next,
    output logic signed [FEATURE_WIDTH-1:0] result
);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-FEATURE_WIDTH+1){1'b0}}, {(FEATURE_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-FEATURE_WIDTH+1){1'b1}}, {(FEATURE_WIDTH-1){1'b0}}};

    logic signed [ACC_W-1:0] w_x;
    logic signed [ACC_W-1:0] w_shifted;

    // Sign-extend the sample so max and sum both work at accumulator width.
    assign w_x       = ACC_W'(sample);
    assign w_shifted = acc_next >>> shift;

    // Combine: first sample loads, later samples take max or running sum.
    always_comb begin
        acc_next = w_x;
        if (!first) begin
            if (mode == POOL_MODE_AVG) begin
                acc_next = acc + w_x;
            end else begin
                acc_next = (w_x > acc) ? w_x : acc;
            end
        end
    end

    // Finalise: max result already fits; average is shifted then clipped.
    always_comb begin
        result = acc_next[FEATURE_WIDTH-1:0];
        if (mode == POOL_MODE_AVG) begin
            if (w_shifted > SAT_MAX) begin
                result = SAT_MAX[FEATURE_WIDTH-1:0];
            end else if (w_shifted < SAT_MIN) begin
                result = SAT_MIN[FEATURE_WIDTH-1:0];
            end else begin
                result = w_shifted[FEATURE_WIDTH-1:0];
            end
        end
    end

endmodule : pool_lane_alu
`default_nettype wire

// File: rtl/pool_window_pe.sv
`default_nettype none
// ============================================================================
//  Module      : pool_window_pe
//  Description : Multi-lane streaming max/average pooling over a serial window.
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_window_pe
    import pool_window_pe_pkg::*;
#(
    parameter int FEATURE_WIDTH = FEATURE_WIDTH_DEF,
    parameter int LANES         = 4,
    parameter int MAX_WIN       = 16,
    parameter int CNT_W         = $clog2(MAX_WIN+1)
)(
    input  logic               DSP_clk,
    input  logic               rst,
    input  logic               cfg_mode,
    input  logic [CNT_W-1:0]   cfg_win_len,
    input  logic [3:0]         cfg_avg_shift,
    pool_window_pe_if.slave    bus,
    output logic               busy
);
    localparam int ACC_W = FEATURE_WIDTH + $clog2(MAX_WIN);

    pool_state_t                     r_state;
    pool_state_t                     w_state_nxt;
    logic [CNT_W-1:0]                r_count;
    logic [CNT_W-1:0]                r_win_len;
    logic                            r_mode;
    logic [3:0]                      r_shift;
    logic                            r_out_valid;
    logic [LANES*FEATURE_WIDTH-1:0]  r_out_data;
    logic [LANES*FEATURE_WIDTH-1:0]  w_result_flat;

    logic [CNT_W-1:0]  w_clamped;
    logic [CNT_W-1:0]  w_win_len;
    logic              w_mode;
    logic [3:0]        w_shift;
    logic              w_first;
    logic              w_last;
    logic              w_accept;
    logic              w_pop;

    // Clamp the requested window length into 1..MAX_WIN.
    always_comb begin
        w_clamped = cfg_win_len;
        if (cfg_win_len == '0) begin
            w_clamped = CNT_W'(1);
        end else if (cfg_win_len > CNT_W'(MAX_WIN)) begin
            w_clamped = CNT_W'(MAX_WIN);
        end
    end

    // On the first sample the live config applies; afterwards the latched copy.
    assign w_first   = (r_state == ST_IDLE);
    assign w_mode    = w_first ? cfg_mode      : r_mode;
    assign w_shift   = w_first ? cfg_avg_shift : r_shift;
    assign w_win_len = w_first ? w_clamped     : r_win_len;
    assign w_last    = (r_count == (w_win_len - CNT_W'(1)));

    // Only the closing sample needs the output register free.
    assign bus.in_ready  = ~(w_last & r_out_valid & ~bus.out_ready);
    assign w_accept      = bus.in_valid & bus.in_ready;
    assign w_pop         = r_out_valid & bus.out_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign busy          = (r_state == ST_ACCUM);

    // State register.
    always_ff @(posedge DSP_clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: open a window on a non-final first accept, close on the last.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && !w_last) w_state_nxt = ST_ACCUM;
            ST_ACCUM: if (w_accept && w_last)  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Sample counter and per-window config latch.
    always_ff @(posedge DSP_clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_win_len <= '0;
            r_mode    <= POOL_MODE_MAX;
            r_shift   <= '0;
        end else if (w_accept) begin
            r_count <= w_last ? '0 : r_count + CNT_W'(1);
            if (w_first) begin
                r_mode    <= cfg_mode;
                r_win_len <= w_clamped;
                r_shift   <= cfg_avg_shift;
            end
        end
    end

    // Single output register; a new result may replace the one being popped.
    always_ff @(posedge DSP_clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_accept && w_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result_flat;
        end else if (w_pop) begin
            r_out_valid <= 1'b0;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lanes
        logic signed [ACC_W-1:0]         r_acc;
        logic signed [ACC_W-1:0]         w_acc_nxt;
        logic signed [FEATURE_WIDTH-1:0] w_res;

        pool_lane_alu #(
            .FEATURE_WIDTH (FEATURE_WIDTH),
            .ACC_W         (ACC_W)
        ) u_alu (
            .mode     (w_mode),
            .first    (w_first),
            .shift    (w_shift),
            .acc      (r_acc),
            .sample   (bus.in_data[i*FEATURE_WIDTH +: FEATURE_WIDTH]),
            .acc_next (w_acc_nxt),
            .result   (w_res)
        );

        assign w_result_flat[i*FEATURE_WIDTH +: FEATURE_WIDTH] = w_res;

        // Per-lane accumulator advances on every accepted sample.
        always_ff @(posedge DSP_clk or posedge rst) begin
            if (rst) begin
                r_acc <= '0;
            end else if (w_accept) begin
                r_acc <= w_acc_nxt;
            end
        end
    end

endmodule : pool_window_pe
`default_nettype wire

// File: tb/tb_pool_window_pe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pool_window_pe
//  Description : Directed self-checking bench for pool_window_pe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_window_pe;
    localparam int FW    = 16;
    localparam int LANES = 4;
    localparam int CNT_W = 5;

    logic             DSP_clk = 1'b0;
    logic             rst;
    logic             cfg_mode;
    logic [CNT_W-1:0] cfg_win_len;
    logic [3:0]       cfg_avg_shift;
    logic             busy;

    int tests = 0;
    int fails = 0;

    pool_window_pe_if #(.LANES(LANES), .FEATURE_WIDTH(FW)) bus ();

    pool_window_pe #(
        .FEATURE_WIDTH (FW),
        .LANES         (LANES),
        .MAX_WIN       (16),
        .CNT_W         (CNT_W)
    ) dut (
        .DSP_clk       (DSP_clk),
        .rst           (rst),
        .cfg_mode      (cfg_mode),
        .cfg_win_len   (cfg_win_len),
        .cfg_avg_shift (cfg_avg_shift),
        .bus           (bus),
        .busy          (busy)
    );

    always #5 DSP_clk = ~DSP_clk;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [31:0] lane(input int i);
        logic signed [FW-1:0] v;
        v = bus.out_data[i*FW +: FW];
        return v;
    endfunction

    // Present one sample vector and wait (bounded) until it is accepted.
    task automatic send(input logic signed [FW-1:0] a, input logic signed [FW-1:0] b,
                        input logic signed [FW-1:0] c, input logic signed [FW-1:0] d);
        int n = 0;
        bus.in_data  = {d, c, b, a};
        bus.in_valid = 1'b1;
        @(negedge DSP_clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge DSP_clk);
            n++;
        end
        if (!bus.in_ready) check("ready_timeout", 0, 1);
        @(posedge DSP_clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input int e0, input int e1,
                             input int e2, input int e3);
        check({tag, "_valid"}, 32'(bus.out_valid), 1);
        check({tag, "_l0"}, lane(0), e0);
        check({tag, "_l1"}, lane(1), e1);
        check({tag, "_l2"}, lane(2), e2);
        check({tag, "_l3"}, lane(3), e3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        cfg_mode      = 1'b0;
        cfg_win_len   = 5'd4;
        cfg_avg_shift = 4'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge DSP_clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(posedge DSP_clk);
        #1;

        // Max, window 4.
        send(3, -1, 100, -32768);
        check("max_busy", 32'(busy), 1);
        send(-7, -2, -100, -32768);
        send(12, -3, 50, -32768);
        check("max_no_early", 32'(bus.out_valid), 0);
        send(5, -4, 99, -32767);
        check_out("max", 12, -1, 100, -32767);
        check("max_idle", 32'(busy), 0);

        // Average, window 4, shift 2.
        cfg_mode = 1'b1; cfg_avg_shift = 4'd2;
        send(10, -5, 1, -1);
        send(20, -5, 1, 0);
        send(30, -5, 1, 0);
        send(41, -6, 0, 0);
        check_out("avg", 25, -6, 0, -1);

        // Average saturation, window 16, shift 0.
        cfg_win_len = 5'd16; cfg_avg_shift = 4'd0;
        for (int k = 0; k < 16; k++) send(32767, 32767, -32768, -32768);
        check_out("sat", 32767, 32767, -32768, -32768);

        // Backpressure: hold result, stall final sample of next window.
        cfg_mode = 1'b0; cfg_win_len = 5'd4;
        @(posedge DSP_clk); #1;
        bus.out_ready = 1'b0;
        send(1, 1, 1, 1); send(2, 2, 2, 2); send(3, 3, 3, 3); send(4, 4, 4, 4);
        repeat (2) @(posedge DSP_clk);
        #1;
        check_out("bp_hold", 4, 4, 4, 4);
        send(9, 9, 9, 9); send(8, 8, 8, 8); send(7, 7, 7, 7);
        bus.in_data  = {16'sd6, 16'sd6, 16'sd6, 16'sd6};
        bus.in_valid = 1'b1;
        @(negedge DSP_clk);
        check("bp_stall", 32'(bus.in_ready), 0);
        @(posedge DSP_clk); #1;
        check_out("bp_still_old", 4, 4, 4, 4);
        check("bp_busy", 32'(busy), 1);
        @(negedge DSP_clk);
        bus.out_ready = 1'b1;
        #1;
        check("bp_release", 32'(bus.in_ready), 1);
        @(posedge DSP_clk); #1;
        bus.in_valid = 1'b0;
        check_out("bp_swap", 9, 9, 9, 9);
        @(posedge DSP_clk); #1;
        check("bp_popped", 32'(bus.out_valid), 0);

        // Config change mid-window is ignored.
        cfg_mode = 1'b0; cfg_win_len = 5'd4;
        send(5, 0, 0, 0); send(9, 0, 0, 0);
        cfg_mode = 1'b1; cfg_win_len = 5'd2;
        check("cfg_no_close2", 32'(bus.out_valid), 0);
        send(1, 0, 0, 0);
        check("cfg_no_close3", 32'(bus.out_valid), 0);
        send(2, 0, 0, 0);
        check_out("cfg", 9, 0, 0, 0);

        // Reset mid-window discards the partial window.
        cfg_mode = 1'b0; cfg_win_len = 5'd4;
        @(posedge DSP_clk); #1;
        send(100, 100, 100, 100); send(200, 200, 200, 200);
        rst = 1'b1;
        #1;
        check("mrst_out_valid", 32'(bus.out_valid), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_in_ready", 32'(bus.in_ready), 1);
        @(posedge DSP_clk); #1;
        rst = 1'b0;
        send(1, -5, 0, 7); send(2, -6, 0, 7); send(3, -7, 0, 7);
        check("mrst_no_early", 32'(bus.out_valid), 0);
        send(-4, -8, 0, 7);
        check_out("mrst", 3, -5, 0, 7);

        // win_len 0 behaves as 1: each sample produces a result next edge.
        cfg_win_len = 5'd0;
        send(7, -3, 1, 0);
        check_out("w0_a", 7, -3, 1, 0);
        check("w0_busy", 32'(busy), 0);
        send(-3, 8, 2, -1);
        check_out("w0_b", -3, 8, 2, -1);
        cfg_mode = 1'b1; cfg_avg_shift = 4'd1;
        send(9, -9, 0, 1);
        check_out("w0_avg", 4, -5, 0, 0);

        @(posedge DSP_clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_pool_window_pe
`default_nettype wire
